expr_arbiter: RTL

- Shares one incremental expression recogniser between two byte-stream requesters, round-robin, one whole expression at a time.
- Accepted grammar: digit (op digit)*, where digit is ASCII '0'..'9' and op is '+' or '*'.
- Each expression is a packet that ends with a last-flagged byte.
- For every packet the block returns a verdict with requester id, byte count and abort flag. It sits between the character sources and the checker result sink.

---
 rtl/expr_pkg.sv | 35 +++
 rtl/expr_recog.sv | 28 ++
 rtl/expr_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared constants, state encodings and the recogniser step function for expr_arbiter.
package expr_pkg;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      REPORT = 2'd2
   } ctrl_state_e;

   typedef enum logic [1:0] {
      E_DIG = 2'd0,
      E_OP  = 2'd1,
      ERR   = 2'd2
   } rec_state_e;

   // One recogniser transition: digit (op digit)*, anything unexpected is sticky ERR.
   function automatic rec_state_e recog_step(rec_state_e st, logic [7:0] ch);
      logic is_dig;
      logic is_op;
      is_dig = (ch >= CH_0) && (ch <= CH_9);
      is_op  = (ch == CH_PLUS) || (ch == CH_STAR);
      recog_step = ERR;
      case (st)
         E_DIG:   if (is_dig) recog_step = E_OP;
         E_OP:    if (is_op)  recog_step = E_DIG;
         default: recog_step = ERR;
      endcase
   endfunction

endpackage

// File: rtl/expr_recog.sv
// Incremental expression recogniser: advances one state per strobed byte.
module expr_recog
   import expr_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       sclr_i,
   input  logic [7:0] byte_i,
   input  logic       stb_i,
   output logic [1:0] state_o
);

   rec_state_e state_q;

   // Recogniser state: sync clear between packets has priority over a byte.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= E_DIG;
      end else if (sclr_i) begin
         state_q <= E_DIG;
      end else if (stb_i) begin
         state_q <= recog_step(state_q, byte_i);
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/expr_arbiter.sv
// Round-robin arbiter sharing one expression recogniser between two byte streams,
// one whole packet per grant, returning a verdict per packet.
module expr_arbiter
   import expr_pkg::*;
#(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       res_ok,
   output logic       res_abort,
   output logic       res_id,
   output logic [7:0] res_len
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   ctrl_state_e       state_q;
   logic              grant_q;
   logic              rr_q;
   logic [7:0]        len_q;
   logic              ovf_q;
   logic [IDLE_W-1:0] idle_q;
   logic              res_valid_q;
   logic              res_ok_q;
   logic              res_abort_q;
   logic              res_id_q;
   logic [7:0]        res_len_q;

   logic              g_valid;
   logic [7:0]        g_data;
   logic              g_last;
   logic              stream;
   logic              accept;
   logic              timeout_hit;
   logic              rec_clear;
   logic [1:0]        rec_state;
   rec_state_e        byte_state;
   logic [7:0]        len_inc;
   logic              ovf_inc;

   // Granted requester view and per-cycle event decode.
   always_comb begin
      g_valid     = grant_q ? req1_valid : req0_valid;
      g_data      = grant_q ? req1_data  : req0_data;
      g_last      = grant_q ? req1_last  : req0_last;
      stream      = (state_q == STREAM);
      accept      = stream && g_valid;
      timeout_hit = stream && !g_valid && (idle_q == IDLE_W'(TIMEOUT - 1));
      rec_clear   = (state_q == REPORT) && res_ready;
      byte_state  = recog_step(rec_state_e'(rec_state), g_data);
      len_inc     = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
      // Overflow is tracked separately so len saturation cannot hide it.
      ovf_inc     = ovf_q || (len_q >= 8'(MAX_LEN));
   end

   assign req0_ready = stream && !grant_q;
   assign req1_ready = stream &&  grant_q;
   assign res_valid  = res_valid_q;
   assign res_ok     = res_ok_q;
   assign res_abort  = res_abort_q;
   assign res_id     = res_id_q;
   assign res_len    = res_len_q;

   expr_recog u_recog (
      .clk     (clk),
      .clr     (clr),
      .sclr_i  (rec_clear),
      .byte_i  (g_data),
      .stb_i   (accept),
      .state_o (rec_state)
   );

   // Controller FSM: grant, stream bytes, hold verdict until the sink takes it.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         rr_q        <= 1'b0;
         len_q       <= 8'd0;
         ovf_q       <= 1'b0;
         idle_q      <= '0;
         res_valid_q <= 1'b0;
         res_ok_q    <= 1'b0;
         res_abort_q <= 1'b0;
         res_id_q    <= 1'b0;
         res_len_q   <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0_valid || req1_valid) begin
                  grant_q <= (req0_valid && req1_valid) ? rr_q : req1_valid;
                  state_q <= STREAM;
               end
            end
            STREAM: begin
               if (g_valid) begin
                  len_q  <= len_inc;
                  ovf_q  <= ovf_inc;
                  idle_q <= '0;
                  if (g_last) begin
                     state_q     <= REPORT;
                     res_valid_q <= 1'b1;
                     res_ok_q    <= (byte_state == E_OP) && !ovf_inc;
                     res_abort_q <= 1'b0;
                     res_id_q    <= grant_q;
                     res_len_q   <= len_inc;
                  end
               end else if (timeout_hit) begin
                  state_q     <= REPORT;
                  res_valid_q <= 1'b1;
                  res_ok_q    <= 1'b0;
                  res_abort_q <= 1'b1;
                  res_id_q    <= grant_q;
                  res_len_q   <= len_q;
               end else begin
                  idle_q <= idle_q + IDLE_W'(1);
               end
            end
            REPORT: begin
               if (res_ready) begin
                  rr_q        <= ~res_id_q;
                  len_q       <= 8'd0;
                  ovf_q       <= 1'b0;
                  idle_q      <= '0;
                  res_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
